// File: rtl/serial_pkg.sv
// serial_pkg: line levels and frame FSM encodings shared by the serial link transmitter and receiver
package serial_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_LVL = 1'b0;

endpackage

// File: rtl/bit_tick_gen.sv
// bit_tick_gen: counts clk cycles within one bit and flags the last cycle of each bit
module bit_tick_gen
   import serial_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic clrN,
   input  logic start_i,
   input  logic run_i,
   output logic bit_tick_o
);

   localparam int TW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

   logic [TW-1:0] tick_q, tick_d;

   // restart on accept, hold while idle, otherwise wrap at the last cycle of the bit
   always_comb tick_d = start_i ? '0 : !run_i ? tick_q : (tick_q == LAST) ? '0 : tick_q + 1'b1;

   // tick counter register
   always_ff @(posedge clk or negedge clrN)
      if (!clrN) tick_q <= '0;
      else tick_q <= tick_d;

   assign bit_tick_o = run_i && (tick_q == LAST);

endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: framed serial transmitter (start, LSB-first data, optional even parity, stop)
module serial_frame_tx
   import serial_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_EN    = 0
) (
   input  logic              clk,
   input  logic              clrN,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              tx_out,
   output logic              tx_busy,
   output logic              tx_done
);

   localparam int BW = $clog2(DATA_W + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

   state_t            state_q;
   logic [DATA_W-1:0] shift_q;
   logic [BW-1:0]     bit_q;
   logic              par_q, out_q, ready_q, done_q;
   logic              accept, bit_tick;

   assign accept = tx_valid && ready_q;

   bit_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
      .clk        (clk),
      .clrN       (clrN),
      .start_i    (accept),
      .run_i      (!ready_q),
      .bit_tick_o (bit_tick)
   );

   // frame sequencer: every line level is registered, so the next bit is loaded at the tick edge
   always_ff @(posedge clk or negedge clrN)
      if (!clrN) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         bit_q   <= '0;
         par_q   <= 1'b0;
         out_q   <= LINE_IDLE;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE:
               if (accept) begin
                  state_q <= ST_START;
                  shift_q <= tx_data;
                  par_q   <= ^tx_data;
                  bit_q   <= '0;
                  out_q   <= START_LVL;
                  ready_q <= 1'b0;
               end
            ST_START:
               if (bit_tick) begin
                  state_q <= ST_DATA;
                  out_q   <= shift_q[0];
                  shift_q <= shift_q >> 1;
               end
            ST_DATA:
               if (bit_tick) begin
                  if (bit_q == LAST_BIT) begin
                     state_q <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                     out_q   <= (PARITY_EN != 0) ? par_q : LINE_IDLE;
                  end else begin
                     bit_q   <= bit_q + 1'b1;
                     out_q   <= shift_q[0];
                     shift_q <= shift_q >> 1;
                  end
               end
            ST_PARITY:
               if (bit_tick) begin
                  state_q <= ST_STOP;
                  out_q   <= LINE_IDLE;
               end
            ST_STOP:
               if (bit_tick) begin
                  state_q <= ST_IDLE;
                  ready_q <= 1'b1;
                  done_q  <= 1'b1;
               end
            default: state_q <= ST_IDLE;
         endcase
      end

   assign tx_ready = ready_q;
   assign tx_busy  = !ready_q;
   assign tx_out   = out_q;
   assign tx_done  = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: three transmitter configurations checked against a frame-level bitstream model
module tb_serial_frame_tx;

   logic       clk = 1'b0, clrN = 1'b1, run = 1'b0;
   logic [7:0] d[3];
   logic       v[3], rdy[3], o[3], bsy[3], dn[3];
   int         checks = 0, errors = 0;

   always #5 if (run) clk = ~clk;

   serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u0 (
      .clk(clk), .clrN(clrN), .tx_data(d[0]), .tx_valid(v[0]),
      .tx_ready(rdy[0]), .tx_out(o[0]), .tx_busy(bsy[0]), .tx_done(dn[0]));
   serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u1 (
      .clk(clk), .clrN(clrN), .tx_data(d[1]), .tx_valid(v[1]),
      .tx_ready(rdy[1]), .tx_out(o[1]), .tx_busy(bsy[1]), .tx_done(dn[1]));
   serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) u2 (
      .clk(clk), .clrN(clrN), .tx_data(d[2]), .tx_valid(v[2]),
      .tx_ready(rdy[2]), .tx_out(o[2]), .tx_busy(bsy[2]), .tx_done(dn[2]));

   // Sends word w on instance k and checks every cycle of the frame against the expected
   // bitstream; waits returns the number of edges until accept (1 = accepted on the first edge).
   task automatic send_frame(input int k, input logic [7:0] w, input bit hold,
                             input logic [7:0] nxt, output int waits);
      bit         q[$];
      int         cpb, len;
      logic [7:0] rec;
      bit         ok;
      cpb = (k == 2) ? 1 : 4;
      q.push_back(1'b0);
      for (int j = 0; j < 8; j++) q.push_back(w[j]);
      if (k == 1) q.push_back(^w);
      q.push_back(1'b1);
      len = q.size() * cpb;
      d[k] = w;
      v[k] = 1'b1;
      waits = 0;
      while (1) begin
         ok = rdy[k];
         @(posedge clk);
         waits++;
         @(negedge clk);
         if (ok || waits >= 100) break;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL accept%0d: tx_ready never seen, got 0 want 1", k);
         v[k] = 1'b0;
         return;
      end
      if (!hold) v[k] = 1'b0;
      rec = '0;
      for (int i = 0; i < len; i++) begin
         if (i == len / 2) d[k] = hold ? 8'h00 : 8'($urandom);
         checks++;
         if ({o[k], rdy[k], bsy[k], dn[k]} !== {q[i / cpb], 3'b010}) begin
            errors++;
            $display("FAIL frame%0d w=%h cyc%0d: out/rdy/busy/done got %b want %b", k, w, i,
                     {o[k], rdy[k], bsy[k], dn[k]}, {q[i / cpb], 3'b010});
         end
         if (i % cpb == cpb / 2 && i / cpb >= 1 && i / cpb <= 8) rec[i / cpb - 1] = o[k];
         @(negedge clk);
      end
      if (hold) d[k] = nxt;
      checks++;
      if ({o[k], rdy[k], bsy[k], dn[k]} !== 4'b1101) begin
         errors++;
         $display("FAIL done%0d w=%h: out/rdy/busy/done got %b want 1101", k, w,
                  {o[k], rdy[k], bsy[k], dn[k]});
      end
      checks++;
      if (rec !== w) begin
         errors++;
         $display("FAIL loopback%0d: got %h want %h", k, rec, w);
      end
      if (!hold) begin
         @(negedge clk);
         checks++;
         if ({o[k], rdy[k], bsy[k], dn[k]} !== 4'b1100) begin
            errors++;
            $display("FAIL idle%0d: out/rdy/busy/done got %b want 1100", k,
                     {o[k], rdy[k], bsy[k], dn[k]});
         end
      end
   endtask

   task automatic test_reset();
      #5 clrN = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({o[k], rdy[k], bsy[k], dn[k]} !== 4'b1100) begin
            errors++;
            $display("FAIL reset%0d: out/rdy/busy/done got %b want 1100", k,
                     {o[k], rdy[k], bsy[k], dn[k]});
         end
      end
      #4 clrN = 1'b1;
      run = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int w;
      send_frame(0, 8'hA5, 1'b0, 8'h00, w);
   endtask

   task automatic test_parity();
      int w;
      send_frame(1, 8'h07, 1'b0, 8'h00, w);
      send_frame(1, 8'h03, 1'b0, 8'h00, w);
   endtask

   task automatic test_back_to_back();
      int w;
      send_frame(0, 8'h01, 1'b1, 8'hFF, w);
      send_frame(0, 8'hFF, 1'b0, 8'h00, w);
      checks++;
      if (w !== 1) begin
         errors++;
         $display("FAIL back_to_back: accept after %0d edges want 1", w);
      end
   endtask

   task automatic test_reset_mid_frame();
      int w, seen;
      d[0] = 8'hA5;
      v[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      v[0] = 1'b0;
      repeat (17) @(negedge clk);
      checks++;
      if (o[0] !== 1'b0) begin
         errors++;
         $display("FAIL mid_bit3: tx_out got %b want 0", o[0]);
      end
      #2 clrN = 1'b0;
      #1;
      checks++;
      if ({o[0], rdy[0], bsy[0], dn[0]} !== 4'b1100) begin
         errors++;
         $display("FAIL async_clr: out/rdy/busy/done got %b want 1100",
                  {o[0], rdy[0], bsy[0], dn[0]});
      end
      #1 clrN = 1'b1;
      seen = 0;
      repeat (50) begin
         @(negedge clk);
         if (dn[0] || !rdy[0] || !o[0]) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL abandoned: %0d cycles with done/busy/low line, want 0", seen);
      end
      send_frame(0, 8'h5A, 1'b0, 8'h00, w);
      checks++;
      if (w !== 1) begin
         errors++;
         $display("FAIL post_clr_accept: accept after %0d edges want 1", w);
      end
   endtask

   task automatic test_cpb1();
      int w;
      send_frame(2, 8'hC3, 1'b0, 8'h00, w);
   endtask

   task automatic test_random();
      int w;
      repeat (8) send_frame(int'($urandom_range(0, 2)), 8'($urandom), 1'b0, 8'h00, w);
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         d[k] = '0;
         v[k] = 1'b0;
      end
      test_reset();
      test_basic();
      test_parity();
      test_back_to_back();
      test_reset_mid_frame();
      test_cpb1();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
